// File: rtl/mpu_req_arbiter_pkg.sv
// Shared sizing, FSM state encoding and the latched request record for the
// MPU request arbiter.
package mpu_req_arbiter_pkg;

    localparam int CORE_COUNT              = 4;
    localparam int CORE_ID_WIDTH           = $clog2(CORE_COUNT);
    localparam int BLOCK_COUNT_BITS        = 8;
    localparam int ADDR_WIDTH              = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    typedef struct packed {
        logic                        fr;
        logic [BLOCK_COUNT_BITS-1:0] num_blocks;
        logic [ADDR_WIDTH-1:0]       addr;
        logic [CORE_COUNT-1:0]       read_mask;
        logic [CORE_COUNT-1:0]       write_mask;
    } mpu_req_t;

endpackage

// File: rtl/mpu_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request bit at or after ptr_i,
// wrapping modulo CORE_COUNT.
module mpu_req_arbiter_rr_arbiter
    import mpu_req_arbiter_pkg::*;
(
    input  logic [CORE_COUNT-1:0]    req_i,
    input  logic [CORE_ID_WIDTH-1:0] ptr_i,
    output logic [CORE_COUNT-1:0]    grant_o,
    output logic [CORE_ID_WIDTH-1:0] grant_idx_o
);

    logic [CORE_ID_WIDTH:0]   sum;
    logic [CORE_ID_WIDTH-1:0] idx;
    logic                     found;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < CORE_COUNT; k++) begin
            sum = {1'b0, ptr_i} + (CORE_ID_WIDTH+1)'(k);
            if (sum >= (CORE_ID_WIDTH+1)'(CORE_COUNT)) begin
                sum = sum - (CORE_ID_WIDTH+1)'(CORE_COUNT);
            end
            idx = sum[CORE_ID_WIDTH-1:0];
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/mpu_req_arbiter.sv
// Round-robin initiator that serialises per-core malloc/free requests into the
// MPU and returns base_addr or a timeout to the requesting core.
module mpu_req_arbiter
    import mpu_req_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [CORE_COUNT-1:0]                  req_valid,
    output logic [CORE_COUNT-1:0]                  req_ready,
    input  logic [CORE_COUNT-1:0]                  req_fr,
    input  logic [CORE_COUNT*BLOCK_COUNT_BITS-1:0] req_num_blocks,
    input  logic [CORE_COUNT*ADDR_WIDTH-1:0]       req_addr,
    input  logic [CORE_COUNT*CORE_COUNT-1:0]       req_read_mask,
    input  logic [CORE_COUNT*CORE_COUNT-1:0]       req_write_mask,
    output logic [CORE_COUNT-1:0]                  resp_valid,
    output logic [ADDR_WIDTH-1:0]                  resp_base_addr,
    output logic                                   resp_timeout,
    output logic                                   mpu_start,
    output logic [CORE_ID_WIDTH-1:0]               mpu_core_id,
    output logic                                   mpu_fr,
    output logic [BLOCK_COUNT_BITS-1:0]            mpu_num_blocks,
    output logic [ADDR_WIDTH-1:0]                  mpu_addr,
    output logic [CORE_COUNT-1:0]                  mpu_read_mask,
    output logic [CORE_COUNT-1:0]                  mpu_write_mask,
    input  logic                                   mpu_rdy,
    input  logic                                   mpu_bsy,
    input  logic [ADDR_WIDTH-1:0]                  mpu_base_addr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t               state_q;
    logic [CORE_ID_WIDTH-1:0] rr_ptr_q;
    logic [CORE_ID_WIDTH-1:0] rr_ptr_d;
    logic [CNT_W-1:0]         wait_cnt_q;
    logic [CORE_ID_WIDTH-1:0] core_id_q;
    mpu_req_t                 req_q;
    logic [ADDR_WIDTH-1:0]    resp_base_q;
    logic                     resp_timeout_q;

    logic [CORE_COUNT-1:0]    grant;
    logic [CORE_ID_WIDTH-1:0] grant_idx;
    mpu_req_t                 cand [CORE_COUNT];

    for (genvar i = 0; i < CORE_COUNT; i++) begin : g_cand
        assign cand[i] = '{
            fr:         req_fr[i],
            num_blocks: req_num_blocks[i*BLOCK_COUNT_BITS +: BLOCK_COUNT_BITS],
            addr:       req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
            read_mask:  req_read_mask[i*CORE_COUNT +: CORE_COUNT],
            write_mask: req_write_mask[i*CORE_COUNT +: CORE_COUNT]
        };
    end

    mpu_req_arbiter_rr_arbiter u_rr (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Pointer moves just past the core that was served, so it becomes lowest priority.
    assign rr_ptr_d = (core_id_q == CORE_ID_WIDTH'(CORE_COUNT - 1)) ? '0
                                                                     : core_id_q + CORE_ID_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the request latch is reset too; it drives mpu_* outputs that must read 0 after reset.
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            wait_cnt_q     <= '0;
            core_id_q      <= '0;
            req_q          <= '0;
            resp_base_q    <= '0;
            resp_timeout_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid && !mpu_bsy) begin
                        req_q     <= cand[grant_idx];
                        core_id_q <= grant_idx;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mpu_rdy) begin
                        resp_base_q    <= mpu_base_addr;
                        resp_timeout_q <= 1'b0;
                        state_q        <= ST_RESP;
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        resp_base_q    <= '0;
                        resp_timeout_q <= 1'b1;
                        state_q        <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready      = (state_q == ST_IDLE && !mpu_bsy) ? grant : '0;
    assign mpu_start      = (state_q == ST_ISSUE);
    assign resp_valid     = (state_q == ST_RESP) ? (CORE_COUNT'(1) << core_id_q) : '0;
    assign resp_base_addr = resp_base_q;
    assign resp_timeout   = resp_timeout_q;
    assign mpu_core_id    = core_id_q;
    assign mpu_fr         = req_q.fr;
    assign mpu_num_blocks = req_q.num_blocks;
    assign mpu_addr       = req_q.addr;
    assign mpu_read_mask  = req_q.read_mask;
    assign mpu_write_mask = req_q.write_mask;

endmodule

// File: tb/tb_mpu_req_arbiter.sv
// Directed bench for mpu_req_arbiter: reset, single alloc, fairness, busy
// blocking, timeout, rdy at the limit and stale rdy.
module tb_mpu_req_arbiter;
    import mpu_req_arbiter_pkg::*;

    localparam int TB_TIMEOUT = 8;

    logic                                   clk;
    logic                                   rst;
    logic [CORE_COUNT-1:0]                  req_valid;
    logic [CORE_COUNT-1:0]                  req_ready;
    logic [CORE_COUNT-1:0]                  req_fr;
    logic [CORE_COUNT*BLOCK_COUNT_BITS-1:0] req_num_blocks;
    logic [CORE_COUNT*ADDR_WIDTH-1:0]       req_addr;
    logic [CORE_COUNT*CORE_COUNT-1:0]       req_read_mask;
    logic [CORE_COUNT*CORE_COUNT-1:0]       req_write_mask;
    logic [CORE_COUNT-1:0]                  resp_valid;
    logic [ADDR_WIDTH-1:0]                  resp_base_addr;
    logic                                   resp_timeout;
    logic                                   mpu_start;
    logic [CORE_ID_WIDTH-1:0]               mpu_core_id;
    logic                                   mpu_fr;
    logic [BLOCK_COUNT_BITS-1:0]            mpu_num_blocks;
    logic [ADDR_WIDTH-1:0]                  mpu_addr;
    logic [CORE_COUNT-1:0]                  mpu_read_mask;
    logic [CORE_COUNT-1:0]                  mpu_write_mask;
    logic                                   mpu_rdy;
    logic                                   mpu_bsy;
    logic [ADDR_WIDTH-1:0]                  mpu_base_addr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Observations captured by drive_txn.
    int                          obs_resp_at;
    int                          obs_start_at;
    int                          obs_starts;
    logic [CORE_COUNT-1:0]       obs_resp_vec;
    logic [ADDR_WIDTH-1:0]       obs_base;
    logic                        obs_to;
    logic [CORE_ID_WIDTH-1:0]    obs_core;
    logic                        obs_fr;
    logic [BLOCK_COUNT_BITS-1:0] obs_nb;
    logic [ADDR_WIDTH-1:0]       obs_addr;
    logic [CORE_COUNT-1:0]       obs_rm;
    logic [CORE_COUNT-1:0]       obs_wm;

    mpu_req_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_fr         (req_fr),
        .req_num_blocks (req_num_blocks),
        .req_addr       (req_addr),
        .req_read_mask  (req_read_mask),
        .req_write_mask (req_write_mask),
        .resp_valid     (resp_valid),
        .resp_base_addr (resp_base_addr),
        .resp_timeout   (resp_timeout),
        .mpu_start      (mpu_start),
        .mpu_core_id    (mpu_core_id),
        .mpu_fr         (mpu_fr),
        .mpu_num_blocks (mpu_num_blocks),
        .mpu_addr       (mpu_addr),
        .mpu_read_mask  (mpu_read_mask),
        .mpu_write_mask (mpu_write_mask),
        .mpu_rdy        (mpu_rdy),
        .mpu_bsy        (mpu_bsy),
        .mpu_base_addr  (mpu_base_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic int oh2idx(input logic [CORE_COUNT-1:0] v);
        for (int i = 0; i < CORE_COUNT; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic fr, input logic [7:0] nb,
                           input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm);
        req_fr[i]                  = fr;
        req_num_blocks[i*8 +: 8]   = nb;
        req_addr[i*32 +: 32]       = addr;
        req_read_mask[i*4 +: 4]    = rm;
        req_write_mask[i*4 +: 4]   = wm;
    endtask

    // Entry: at a drive point with inputs set. Exit: at the negedge of the grant cycle.
    task automatic wait_grant(output logic [CORE_COUNT-1:0] vec, output int waited);
        vec    = '0;
        waited = -1;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                vec    = req_ready;
                waited = w;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // Entry: negedge of the accept cycle (cycle 0). Exit: negedge of the response cycle.
    task automatic drive_txn(input int rdy_at, input logic [31:0] base,
                             input bit stale_issue, input bit drop_valid);
        obs_resp_at  = -1;
        obs_start_at = -1;
        obs_starts   = 0;
        obs_resp_vec = '0;
        obs_base     = '0;
        obs_to       = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1 && drop_valid) begin
                req_valid      = '0;
                req_fr         = ~req_fr;
                req_num_blocks = '1;
                req_addr       = '1;
                req_read_mask  = '1;
                req_write_mask = '0;
            end
            mpu_rdy       = (c == rdy_at) || (stale_issue && c == 1);
            mpu_base_addr = (c == rdy_at) ? base : 32'hDEAD_BEEF;
            @(negedge clk);
            if (mpu_start) begin
                obs_starts++;
                obs_start_at = c;
                obs_core     = mpu_core_id;
                obs_fr       = mpu_fr;
                obs_nb       = mpu_num_blocks;
                obs_addr     = mpu_addr;
                obs_rm       = mpu_read_mask;
                obs_wm       = mpu_write_mask;
            end
            if (resp_valid != '0) begin
                obs_resp_at  = c;
                obs_resp_vec = resp_valid;
                obs_base     = resp_base_addr;
                obs_to       = resp_timeout;
                break;
            end
        end
        mpu_rdy = 1'b0;
    endtask

    task automatic test_reset();
        logic [92:0]           all_out;
        logic [CORE_COUNT-1:0] g;
        int                    w;
        bit                    leaked;
        rst = 1'b1;
        req_valid = '0; req_fr = '0; req_num_blocks = '0; req_addr = '0;
        req_read_mask = '0; req_write_mask = '0;
        mpu_rdy = 1'b0; mpu_bsy = 1'b0; mpu_base_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        all_out = {req_ready, resp_valid, mpu_start, mpu_core_id, mpu_fr, mpu_num_blocks, mpu_addr,
                   mpu_read_mask, mpu_write_mask, resp_base_addr, resp_timeout};
        total_cnt++;
        if (all_out !== '0) $display("FAIL reset_state: got %h want 0", all_out);
        else pass_cnt++;

        @(posedge clk); #1;
        set_req(2, 1'b1, 8'h22, 32'h0000_2200, 4'b0100, 4'b0100);
        req_valid = 4'b0100;
        wait_grant(g, w);
        total_cnt++;
        if (g !== 4'b0100) $display("FAIL reset_pre_grant: got %b want 0100", g);
        else pass_cnt++;

        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        total_cnt++;
        if ({mpu_start, mpu_core_id, mpu_num_blocks} !== {1'b1, 2'd2, 8'h22})
            $display("FAIL reset_pre_issue: got start=%b id=%0d nb=%h want 1 2 22",
                     mpu_start, mpu_core_id, mpu_num_blocks);
        else pass_cnt++;

        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        mpu_rdy = 1'b1;
        mpu_base_addr = 32'h0000_0055;
        @(negedge clk);
        all_out = {req_ready, resp_valid, mpu_start, mpu_core_id, mpu_fr, mpu_num_blocks, mpu_addr,
                   mpu_read_mask, mpu_write_mask, resp_base_addr, resp_timeout};
        total_cnt++;
        if (all_out !== '0) $display("FAIL reset_mid_wait: got %h want 0", all_out);
        else pass_cnt++;

        @(posedge clk); #1;
        rst = 1'b0;
        leaked = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid != '0 || mpu_start) leaked = 1'b1;
            @(posedge clk); #1;
        end
        mpu_rdy = 1'b0;
        total_cnt++;
        if (leaked !== 1'b0) $display("FAIL reset_drop: got response/start after reset want none");
        else pass_cnt++;
    endtask

    task automatic test_single_alloc();
        logic [CORE_COUNT-1:0] g;
        int                    w;
        @(posedge clk); #1;
        set_req(1, 1'b1, 8'd4, 32'h0000_0123, 4'b0011, 4'b0010);
        req_valid = 4'b0010;
        wait_grant(g, w);
        total_cnt++;
        if (g !== 4'b0010 || w !== 0) $display("FAIL alloc_grant: got %b after %0d want 0010 after 0", g, w);
        else pass_cnt++;

        drive_txn(7, 32'h0000_0040, 1'b0, 1'b1);
        total_cnt++;
        if (obs_starts !== 1 || obs_start_at !== 1)
            $display("FAIL alloc_start: got %0d pulses at %0d want 1 at 1", obs_starts, obs_start_at);
        else pass_cnt++;
        total_cnt++;
        if ({obs_core, obs_fr, obs_nb, obs_rm, obs_wm} !== {2'd1, 1'b1, 8'd4, 4'b0011, 4'b0010})
            $display("FAIL alloc_fields: got id=%0d fr=%b nb=%0d rm=%b wm=%b want 1 1 4 0011 0010",
                     obs_core, obs_fr, obs_nb, obs_rm, obs_wm);
        else pass_cnt++;
        total_cnt++;
        if (obs_resp_at !== 8 || obs_resp_vec !== 4'b0010)
            $display("FAIL alloc_resp: got %b at %0d want 0010 at 8", obs_resp_vec, obs_resp_at);
        else pass_cnt++;
        total_cnt++;
        if (obs_base !== 32'h40 || obs_to !== 1'b0)
            $display("FAIL alloc_base: got %h to=%b want 00000040 0", obs_base, obs_to);
        else pass_cnt++;

        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++;
        if (resp_valid !== 4'b0000 || resp_base_addr !== 32'h40)
            $display("FAIL alloc_hold: got resp=%b base=%h want 0000 00000040", resp_valid, resp_base_addr);
        else pass_cnt++;
    endtask

    task automatic test_fairness();
        int                    exp_order [5] = '{2, 3, 0, 1, 2};
        logic [CORE_COUNT-1:0] g;
        int                    w;
        @(posedge clk); #1;
        for (int i = 0; i < CORE_COUNT; i++)
            set_req(i, i[0], 8'h10 + 8'(i), 32'h1000 * (i + 1), 4'(1 << i), ~4'(1 << i));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, w);
            total_cnt++;
            if (oh2idx(g) !== exp_order[k] || w !== 0)
                $display("FAIL fair_grant%0d: got core %0d after %0d want core %0d after 0",
                         k, oh2idx(g), w, exp_order[k]);
            else pass_cnt++;
            drive_txn(2, 32'h0000_A000 + k, 1'b0, 1'b0);
            total_cnt++;
            if (obs_nb !== 8'h10 + 8'(exp_order[k]) || obs_resp_at !== 3 ||
                obs_resp_vec !== 4'(1 << exp_order[k]) || obs_base !== 32'h0000_A000 + k)
                $display("FAIL fair_txn%0d: got nb=%h at=%0d resp=%b base=%h want nb=%h at=3 core %0d",
                         k, obs_nb, obs_resp_at, obs_resp_vec, obs_base,
                         8'h10 + 8'(exp_order[k]), exp_order[k]);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic test_busy_block();
        logic [CORE_COUNT-1:0] g;
        int                    w;
        bit                    early;
        @(posedge clk); #1;
        mpu_bsy   = 1'b1;
        req_valid = 4'b0001;
        early     = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (req_ready != '0) early = 1'b1;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (early !== 1'b0) $display("FAIL busy_hold: got req_ready while mpu_bsy want 0000");
        else pass_cnt++;
        mpu_bsy = 1'b0;
        wait_grant(g, w);
        total_cnt++;
        if (g !== 4'b0001 || w !== 0) $display("FAIL busy_release: got %b after %0d want 0001 after 0", g, w);
        else pass_cnt++;
        drive_txn(3, 32'h0000_0C00, 1'b0, 1'b1);
        total_cnt++;
        if (obs_resp_vec !== 4'b0001 || obs_resp_at !== 4 || obs_nb !== 8'h10)
            $display("FAIL busy_txn: got resp=%b at %0d nb=%h want 0001 at 4 nb=10",
                     obs_resp_vec, obs_resp_at, obs_nb);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic [CORE_COUNT-1:0] g;
        int                    w;
        @(posedge clk); #1;
        set_req(1, 1'b1, 8'd9, 32'h0, 4'b0010, 4'b0010);
        req_valid = 4'b0010;
        wait_grant(g, w);
        total_cnt++;
        if (g !== 4'b0010) $display("FAIL timeout_grant: got %b want 0010", g);
        else pass_cnt++;
        drive_txn(0, 32'h0, 1'b0, 1'b1);
        total_cnt++;
        if (obs_resp_vec !== 4'b0010 || obs_resp_at !== 2 + TB_TIMEOUT)
            $display("FAIL timeout_resp: got %b at %0d want 0010 at %0d", obs_resp_vec, obs_resp_at, 2 + TB_TIMEOUT);
        else pass_cnt++;
        total_cnt++;
        if (obs_to !== 1'b1 || obs_base !== 32'h0)
            $display("FAIL timeout_flag: got to=%b base=%h want 1 00000000", obs_to, obs_base);
        else pass_cnt++;
    endtask

    task automatic test_rdy_at_limit();
        logic [CORE_COUNT-1:0] g;
        int                    w;
        @(posedge clk); #1;
        set_req(3, 1'b1, 8'd2, 32'h0, 4'b1000, 4'b1000);
        req_valid = 4'b1000;
        wait_grant(g, w);
        total_cnt++;
        if (g !== 4'b1000) $display("FAIL limit_grant: got %b want 1000", g);
        else pass_cnt++;
        drive_txn(1 + TB_TIMEOUT, 32'h0000_0BEE, 1'b0, 1'b1);
        total_cnt++;
        if (obs_resp_at !== 2 + TB_TIMEOUT || obs_to !== 1'b0 || obs_base !== 32'h0000_0BEE)
            $display("FAIL limit_resp: got at=%0d to=%b base=%h want at=%0d to=0 base=00000bee",
                     obs_resp_at, obs_to, obs_base, 2 + TB_TIMEOUT);
        else pass_cnt++;
    endtask

    task automatic test_stale_rdy();
        logic [CORE_COUNT-1:0] g;
        int                    w;
        @(posedge clk); #1;
        req_valid     = '0;
        mpu_rdy       = 1'b1;
        mpu_base_addr = 32'hDEAD_0000;
        @(negedge clk);
        total_cnt++;
        if (resp_valid !== 4'b0000) $display("FAIL stale_idle: got %b want 0000", resp_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        mpu_rdy = 1'b0;
        set_req(3, 1'b0, 8'd0, 32'h0000_0080, 4'b0000, 4'b0000);
        req_valid = 4'b1000;
        wait_grant(g, w);
        total_cnt++;
        if (g !== 4'b1000 || w !== 0) $display("FAIL stale_grant: got %b after %0d want 1000 after 0", g, w);
        else pass_cnt++;
        drive_txn(5, 32'h0000_0080, 1'b1, 1'b1);
        total_cnt++;
        if (obs_fr !== 1'b0 || obs_addr !== 32'h80 || obs_start_at !== 1)
            $display("FAIL stale_fields: got fr=%b addr=%h start=%0d want 0 00000080 1",
                     obs_fr, obs_addr, obs_start_at);
        else pass_cnt++;
        total_cnt++;
        if (obs_resp_at !== 6 || obs_resp_vec !== 4'b1000 || obs_base !== 32'h80 || obs_to !== 1'b0)
            $display("FAIL stale_resp: got %b at %0d base=%h to=%b want 1000 at 6 base=00000080 to=0",
                     obs_resp_vec, obs_resp_at, obs_base, obs_to);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_alloc();
        test_fairness();
        test_busy_block();
        test_timeout();
        test_rdy_at_limit();
        test_stale_rdy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
